// File: rtl/enemy_field_ctrl.sv
// Falling-enemy column controller: holds per-lane y positions, advances them once per
// frame and sequences the renderer through draw/erase passes with a req/done handshake.
module enemy_field_ctrl #(
  parameter int NUM_ENEMIES = 10,
  parameter int Y_W         = 8,
  parameter int Y_MAX       = 120,
  parameter int RATE_W      = 2,
  parameter int WAIT_CYCLES = 1666667,
  parameter bit WRAP        = 1'b0
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               enable,
  input  logic                               restart,
  input  logic [$clog2(NUM_ENEMIES+1)-1:0]   active_count,
  input  logic [RATE_W-1:0]                  flying_rate,
  input  logic [NUM_ENEMIES-1:0]             destroy,
  input  logic                               render_done,
  output logic                               render_req,
  output logic                               render_erase,
  output logic [NUM_ENEMIES*Y_W-1:0]         y_out,
  output logic [NUM_ENEMIES-1:0]             vis,
  output logic                               frame_tick,
  output logic [NUM_ENEMIES-1:0]             edge_hit,
  output logic                               game_over
);

  localparam int CNT_W  = $clog2(NUM_ENEMIES+1);
  localparam int WAIT_W = $clog2(WAIT_CYCLES);
  localparam logic [Y_W:0]        Y_MAX_EXT = (Y_W+1)'(Y_MAX);
  localparam logic [WAIT_W-1:0]   WAIT_LAST = WAIT_W'(WAIT_CYCLES-1);

  typedef enum logic [2:0] {
    S_DRAW, S_WAIT, S_ERASE, S_UPDATE, S_CHECK, S_OVER
  } state_t;

  state_t                  state_reg;
  logic [WAIT_W-1:0]       wait_cnt_reg;
  logic [NUM_ENEMIES-1:0]  pending_kill_reg;
  logic [Y_W-1:0]          y_reg [NUM_ENEMIES];

  logic [CNT_W-1:0]        act_next;
  logic [NUM_ENEMIES-1:0]  kill_now;
  logic [NUM_ENEMIES-1:0]  vis_next;
  logic [NUM_ENEMIES-1:0]  hit_next;
  logic [Y_W-1:0]          y_next [NUM_ENEMIES];

  assign act_next = (active_count > CNT_W'(NUM_ENEMIES)) ? CNT_W'(NUM_ENEMIES) : active_count;
  // A kill arriving in the update cycle itself still counts for that update.
  assign kill_now = pending_kill_reg | destroy;

  generate
    for (genvar gi = 0; gi < NUM_ENEMIES; gi++) begin : g_lane
      logic [Y_W:0] sum;
      assign sum          = {1'b0, y_reg[gi]} + (Y_W+1)'(flying_rate);
      assign vis_next[gi] = (CNT_W'(gi) < act_next);
      assign hit_next[gi] = vis_next[gi] && !kill_now[gi] && (sum >= Y_MAX_EXT);
      assign y_next[gi]   = (!vis_next[gi] || kill_now[gi]) ? '0 :
                            (sum >= Y_MAX_EXT) ? (WRAP ? '0 : Y_W'(Y_MAX)) :
                            sum[Y_W-1:0];
      assign y_out[gi*Y_W +: Y_W] = y_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg        <= S_DRAW;
      wait_cnt_reg     <= '0;
      pending_kill_reg <= '0;
      for (int i = 0; i < NUM_ENEMIES; i++) y_reg[i] <= '0;
      vis              <= '0;
      edge_hit         <= '0;
      render_req       <= 1'b0;
      render_erase     <= 1'b0;
      frame_tick       <= 1'b0;
      game_over        <= 1'b0;
    end else begin
      frame_tick <= 1'b0;
      if (state_reg != S_OVER && state_reg != S_UPDATE)
        pending_kill_reg <= pending_kill_reg | destroy;

      case (state_reg)
        S_DRAW: begin
          // done only counts once our registered request is actually visible
          if (render_req && render_done) begin
            render_req <= 1'b0;
            state_reg  <= S_WAIT;
          end else begin
            render_req   <= 1'b1;
            render_erase <= 1'b0;
          end
        end
        S_WAIT: begin
          if (enable) begin
            if (wait_cnt_reg == WAIT_LAST) begin
              wait_cnt_reg <= '0;
              state_reg    <= S_ERASE;
            end else begin
              wait_cnt_reg <= wait_cnt_reg + 1'b1;
            end
          end
        end
        S_ERASE: begin
          if (render_req && render_done) begin
            render_req   <= 1'b0;
            render_erase <= 1'b0;
            frame_tick   <= 1'b1;
            state_reg    <= S_UPDATE;
          end else begin
            render_req   <= 1'b1;
            render_erase <= 1'b1;
          end
        end
        S_UPDATE: begin
          for (int i = 0; i < NUM_ENEMIES; i++) y_reg[i] <= y_next[i];
          edge_hit         <= hit_next;
          vis              <= vis_next;
          pending_kill_reg <= '0;
          state_reg        <= S_CHECK;
        end
        S_CHECK: begin
          if ((|edge_hit) && !WRAP) begin
            game_over <= 1'b1;
            state_reg <= S_OVER;
          end else begin
            state_reg <= S_DRAW;
          end
        end
        S_OVER: begin
          if (restart) begin
            for (int i = 0; i < NUM_ENEMIES; i++) y_reg[i] <= '0;
            edge_hit         <= '0;
            pending_kill_reg <= '0;
            game_over        <= 1'b0;
            state_reg        <= S_DRAW;
          end
        end
        default: state_reg <= S_DRAW;
      endcase
    end
  end

endmodule

// File: tb/tb_enemy_field_ctrl.sv
// Randomized bench: two controllers (game-over and wrap modes) against a frame-level model.
module tb_enemy_field_ctrl;
  localparam int N  = 4;
  localparam int YW = 8;
  localparam int YM = 120;
  localparam int WC = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b1;
  logic        restart = 1'b0;
  logic [2:0]  active_count = 3'd2;
  logic [1:0]  flying_rate = 2'd3;
  logic [N-1:0] destroy = '0;
  logic        rdone [2];
  logic        req [2];
  logic        ers [2];
  logic [N*YW-1:0] y_o [2];
  logic [N-1:0] vis_o [2];
  logic        tick [2];
  logic [N-1:0] edge_o [2];
  logic        go [2];

  int check_cnt = 0;
  int err_cnt   = 0;

  always #5 clk = ~clk;

  enemy_field_ctrl #(.NUM_ENEMIES(N), .Y_W(YW), .Y_MAX(YM), .RATE_W(2),
                     .WAIT_CYCLES(WC), .WRAP(1'b0)) dut0 (
    .clk(clk), .reset(reset), .enable(enable), .restart(restart),
    .active_count(active_count), .flying_rate(flying_rate), .destroy(destroy),
    .render_done(rdone[0]), .render_req(req[0]), .render_erase(ers[0]),
    .y_out(y_o[0]), .vis(vis_o[0]), .frame_tick(tick[0]), .edge_hit(edge_o[0]),
    .game_over(go[0]));

  enemy_field_ctrl #(.NUM_ENEMIES(N), .Y_W(YW), .Y_MAX(YM), .RATE_W(2),
                     .WAIT_CYCLES(WC), .WRAP(1'b1)) dut1 (
    .clk(clk), .reset(reset), .enable(enable), .restart(restart),
    .active_count(active_count), .flying_rate(flying_rate), .destroy(destroy),
    .render_done(rdone[1]), .render_req(req[1]), .render_erase(ers[1]),
    .y_out(y_o[1]), .vis(vis_o[1]), .frame_tick(tick[1]), .edge_hit(edge_o[1]),
    .game_over(go[1]));

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    check_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Frame-level model state, one set per instance (index 1 = wrap mode)
  int          my   [2][N];
  logic [N-1:0] m_edge [2];
  logic [N-1:0] m_vis  [2];
  logic [N-1:0] m_pend [2];
  bit          m_go [2];
  bit          in_check [2];
  bit          in_wait [2];
  int          wcnt [2];
  int          ecd [2];
  bit          prev_req [2];
  bit          prev_ers [2];
  bit          last_ers [2];
  bit          upd [2];
  int          frames = 0;

  function automatic logic [N*YW-1:0] packed_y(input int d);
    logic [N*YW-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) v[i*YW +: YW] = YW'(my[d][i]);
    return v;
  endfunction

  // Renderer: answers each request after 0..4 idle cycles, plus stray done pulses while idle
  initial begin
    int lat [2];
    rdone[0] = 1'b0; rdone[1] = 1'b0;
    lat[0] = 0; lat[1] = 0;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (rdone[d]) rdone[d] = 1'b0;
        else if (req[d]) begin
          if (lat[d] == 0) rdone[d] = 1'b1;
          else lat[d]--;
        end else begin
          lat[d] = $urandom_range(0, 4);
          rdone[d] = ($urandom_range(0, 9) == 0);
        end
      end
    end
  end

  initial begin
    int low_burst;
    int act;
    bit found;
    low_burst = 0;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < N; i++) my[d][i] = 0;
      m_edge[d] = '0; m_vis[d] = '0; m_pend[d] = '0; m_go[d] = 0;
      in_check[d] = 0; in_wait[d] = 0; wcnt[d] = 0; ecd[d] = 0;
      prev_req[d] = 0; prev_ers[d] = 0; last_ers[d] = 1; upd[d] = 0;
    end

    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++)
      check_value($sformatf("reset_outputs%0d", d),
                  {y_o[d], vis_o[d], edge_o[d], req[d], ers[d], tick[d], go[d]}, '0);
    reset = 1'b0;

    for (int cyc = 0; cyc < 6000; cyc++) begin
      @(negedge clk);
      // compare DUT state after the previous edge with the model
      for (int d = 0; d < 2; d++) begin
        check_value($sformatf("y%0d", d), y_o[d], packed_y(d));
        check_value($sformatf("edge%0d", d), edge_o[d], m_edge[d]);
        check_value($sformatf("vis%0d", d), vis_o[d], m_vis[d]);
        check_value($sformatf("game_over%0d", d), go[d], m_go[d]);
        upd[d] = prev_req[d] && prev_ers[d] && !req[d];
        check_value($sformatf("frame_tick%0d", d), tick[d], upd[d]);
        if (m_go[d]) check_value($sformatf("req_in_over%0d", d), req[d], 1'b0);
        if (!prev_req[d] && req[d]) begin
          check_value($sformatf("pass_kind%0d", d), ers[d], !last_ers[d]);
          last_ers[d] = ers[d];
        end
        if (in_wait[d]) check_value($sformatf("req_in_wait%0d", d), req[d], 1'b0);
        if (ecd[d] > 0) begin
          ecd[d]--;
          if (ecd[d] == 0) check_value($sformatf("erase_after_wait%0d", d), {req[d], ers[d]}, 2'b11);
          else check_value($sformatf("erase_latency%0d", d), req[d], 1'b0);
        end
        if (prev_req[d] && !prev_ers[d] && !req[d] && !m_go[d]) begin
          in_wait[d] = 1; wcnt[d] = 0;
        end
        prev_req[d] = req[d];
        prev_ers[d] = ers[d];
      end

      // randomized drive for the next edge
      if (low_burst > 0) begin
        low_burst--; enable = 1'b0;
      end else if ($urandom_range(0, 59) == 0) begin
        low_burst = 20; enable = 1'b0;
      end else begin
        enable = ($urandom_range(0, 7) != 0);
      end
      restart = ($urandom_range(0, 7) == 0);
      destroy = ($urandom_range(0, 5) == 0) ? N'($urandom) : '0;
      if ($urandom_range(0, 49) == 0) active_count = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 29) == 0) flying_rate = 2'($urandom_range(0, 3));

      // advance the model with what the DUT will sample on the next edge
      for (int d = 0; d < 2; d++) begin
        if (in_wait[d] && enable) begin
          wcnt[d]++;
          if (wcnt[d] == WC) begin in_wait[d] = 0; ecd[d] = 2; end
        end
        if (!m_go[d]) begin
          if (upd[d]) begin
            act = (int'(active_count) > N) ? N : int'(active_count);
            m_vis[d] = N'((1 << act) - 1);
            for (int i = 0; i < N; i++) begin
              if (i >= act || m_pend[d][i] || destroy[i]) begin
                my[d][i] = 0; m_edge[d][i] = 1'b0;
              end else if (my[d][i] + int'(flying_rate) >= YM) begin
                m_edge[d][i] = 1'b1;
                my[d][i] = (d == 1) ? 0 : YM;
              end else begin
                my[d][i] = my[d][i] + int'(flying_rate);
                m_edge[d][i] = 1'b0;
              end
            end
            m_pend[d] = '0;
            in_check[d] = 1;
            if (d == 0) frames++;
          end else begin
            m_pend[d] = m_pend[d] | destroy;
            if (in_check[d]) begin
              in_check[d] = 0;
              if (d == 0 && |m_edge[d]) m_go[d] = 1;
            end
          end
        end else if (restart) begin
          for (int i = 0; i < N; i++) my[d][i] = 0;
          m_edge[d] = '0; m_pend[d] = '0; m_go[d] = 0;
        end
      end
    end

    // Async reset while the game-over instance is mid erase pass
    found = 0;
    for (int k = 0; k < 400 && !found; k++) begin
      @(negedge clk);
      restart = 1'b1; enable = 1'b1; destroy = '0;
      if (req[0] && ers[0]) begin
        #2 reset = 1'b1;
        #1;
        for (int d = 0; d < 2; d++)
          check_value($sformatf("async_reset%0d", d),
                      {y_o[d], vis_o[d], edge_o[d], req[d], ers[d], tick[d], go[d]}, '0);
        found = 1;
      end
    end
    check_value("reached_erase_for_reset", found, 1'b1);
    check_value("frames_progressed", (frames > 20), 1'b1);
    @(negedge clk);
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", check_cnt, err_cnt);
    $finish;
  end

endmodule
